mcse_gpio_frame_rx: RTL and testbench

Host-side receiver for the framed word stream that the MCSE control unit sends over gpio_out. It takes 32-bit GPIO words under a valid/ready handshake and checks the sync header, length and XOR trailer. It reassembles payloads of up to 8 words, such as SHA digests, Camellia blocks and PUF signatures. Each completed frame is presented on a single-entry output buffer with a valid/ready handshake, and errors are reported as single-cycle pulses.

---
 rtl/mcse_frame_pkg.sv | 29 ++
 rtl/mcse_frame_timeout.sv | 34 +++
 rtl/mcse_gpio_frame_rx.sv | 209 ++++++++++++++++++++
 tb/tb_mcse_gpio_frame_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mcse_frame_pkg.sv
// Shared definitions for the MCSE GPIO frame link: FSM states, header layout,
// sync byte and frame type codes.
package mcse_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } frame_state_e;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;

  // Header word layout: [31:24] sync, [23:16] type, [15:8] len, [7:0] seq
  localparam int unsigned HDR_FIELD_W  = 8;
  localparam int unsigned HDR_SYNC_LSB = 24;
  localparam int unsigned HDR_TYPE_LSB = 16;
  localparam int unsigned HDR_LEN_LSB  = 8;
  localparam int unsigned HDR_SEQ_LSB  = 0;

  localparam logic [7:0] FRAME_TYPE_SHA = 8'h01;
  localparam logic [7:0] FRAME_TYPE_CAM = 8'h02;
  localparam logic [7:0] FRAME_TYPE_PUF = 8'h03;

  // A header length is legal when it is 1..max_words
  function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_words);
    return (len != 8'd0) && (len <= max_words);
  endfunction

endpackage

// File: rtl/mcse_frame_timeout.sv
// Loadable idle counter: clr has priority over load, load over en.
// expire_c is high in the enabled cycle in which the count sits at cycles-1.
module mcse_frame_timeout #(
  parameter int unsigned cycles = 1024,
  parameter int unsigned CNT_W  = $clog2(cycles)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(cycles - 1);

  logic [CNT_W-1:0] cnt;

  assign expire_c = en && (cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= expire_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mcse_gpio_frame_rx.sv
// Host-side receiver for MCSE framed GPIO words: header/length/XOR-trailer
// checks, payload reassembly into a one-entry output buffer, error pulses.
// Optional sequence-gap detection is enabled by defining MCSE_FRAME_SEQ_CHECK_EN.
module mcse_gpio_frame_rx
  import mcse_frame_pkg::*;
#(
  parameter int unsigned gpio_N            = 32,
  parameter int unsigned max_payload_words = 8,
  parameter int unsigned timeout_cycles    = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [gpio_N-1:0]                   gpio_word,
  input  logic                                gpio_valid,
  output logic                                gpio_ready,
  output logic [gpio_N*max_payload_words-1:0] frame_data,
  output logic [7:0]                          frame_type,
  output logic [7:0]                          frame_len,
  output logic [7:0]                          frame_seq,
  output logic                                frame_valid,
  input  logic                                frame_ready,
  output logic                                err_sync,
  output logic                                err_len,
  output logic                                err_chk,
  output logic                                err_timeout,
  output logic                                err_seq,
  output logic [7:0]                          sync_err_cnt
);

  localparam int unsigned DATA_W = gpio_N * max_payload_words;
  localparam int unsigned IDX_W  = (max_payload_words > 1) ? $clog2(max_payload_words) : 1;
  localparam int unsigned TMO_W  = $clog2(timeout_cycles);

  frame_state_e      state, state_d;
  logic [DATA_W-1:0] data_d;
  logic [7:0]        type_d, len_d, seq_d, sync_cnt_d;
  logic              valid_d, ready_d;
  logic              err_sync_d, err_len_d, err_chk_d, err_timeout_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [gpio_N-1:0] chk, chk_d;

  logic       accept_c, tmo_en_c, tmo_clr_c, tmo_expire_c;
  logic [7:0] w_sync, w_type, w_len, w_seq;

  assign accept_c = gpio_valid && gpio_ready;
  assign w_sync   = gpio_word[HDR_SYNC_LSB +: HDR_FIELD_W];
  assign w_type   = gpio_word[HDR_TYPE_LSB +: HDR_FIELD_W];
  assign w_len    = gpio_word[HDR_LEN_LSB  +: HDR_FIELD_W];
  assign w_seq    = gpio_word[HDR_SEQ_LSB  +: HDR_FIELD_W];

  // Idle timer only runs inside a frame and restarts on every accepted word
  assign tmo_en_c  = (state != IDLE) && !accept_c;
  assign tmo_clr_c = (state == IDLE) || accept_c;

  mcse_frame_timeout #(
    .cycles (timeout_cycles),
    .CNT_W  (TMO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmo_clr_c),
    .en       (tmo_en_c),
    .load     (1'b0),
    .load_val ('0),
    .expire_c (tmo_expire_c)
  );

`ifdef MCSE_FRAME_SEQ_CHECK_EN
  logic [7:0] prev_seq, prev_seq_d;
  logic       seq_seen, seq_seen_d, err_seq_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    data_d        = frame_data;
    type_d        = frame_type;
    len_d         = frame_len;
    seq_d         = frame_seq;
    valid_d       = frame_valid;
    sync_cnt_d    = sync_err_cnt;
    idx_d         = idx;
    chk_d         = chk;
    err_sync_d    = 1'b0;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
`ifdef MCSE_FRAME_SEQ_CHECK_EN
    prev_seq_d    = prev_seq;
    seq_seen_d    = seq_seen;
    err_seq_d     = 1'b0;
`endif

    if (frame_valid && frame_ready) begin
      valid_d = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          if (w_sync != FRAME_SYNC) begin
            err_sync_d = 1'b1;
            if (sync_err_cnt != 8'hFF) sync_cnt_d = sync_err_cnt + 8'd1;
          end else if (!len_legal(w_len, 8'(max_payload_words))) begin
            err_len_d = 1'b1;
          end else begin
            type_d  = w_type;
            len_d   = w_len;
            seq_d   = w_seq;
            data_d  = '0;
            chk_d   = gpio_word;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (tmo_expire_c) begin
          err_timeout_d = 1'b1;
          data_d        = '0;
          state_d       = IDLE;
        end else if (accept_c) begin
          data_d[32'(idx) * gpio_N +: gpio_N] = gpio_word;
          chk_d = chk ^ gpio_word;
          if (8'(idx) == frame_len - 8'd1) state_d = TRAILER;
          else                             idx_d   = idx + IDX_W'(1);
        end
      end

      TRAILER: begin
        if (tmo_expire_c) begin
          err_timeout_d = 1'b1;
          data_d        = '0;
          state_d       = IDLE;
        end else if (accept_c) begin
          state_d = IDLE;
          if (gpio_word == chk) begin
            valid_d = 1'b1;
`ifdef MCSE_FRAME_SEQ_CHECK_EN
            err_seq_d  = seq_seen && (frame_seq != prev_seq + 8'd1);
            prev_seq_d = frame_seq;
            seq_seen_d = 1'b1;
`endif
          end else begin
            err_chk_d = 1'b1;
            data_d    = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = !valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      frame_data   <= '0;
      frame_type   <= '0;
      frame_len    <= '0;
      frame_seq    <= '0;
      frame_valid  <= 1'b0;
      gpio_ready   <= 1'b1;
      sync_err_cnt <= '0;
      idx          <= '0;
      chk          <= '0;
      err_sync     <= 1'b0;
      err_len      <= 1'b0;
      err_chk      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      frame_data   <= data_d;
      frame_type   <= type_d;
      frame_len    <= len_d;
      frame_seq    <= seq_d;
      frame_valid  <= valid_d;
      gpio_ready   <= ready_d;
      sync_err_cnt <= sync_cnt_d;
      idx          <= idx_d;
      chk          <= chk_d;
      err_sync     <= err_sync_d;
      err_len      <= err_len_d;
      err_chk      <= err_chk_d;
      err_timeout  <= err_timeout_d;
    end
  end

`ifdef MCSE_FRAME_SEQ_CHECK_EN
  // Sequence tracker; first delivery after reset only primes prev_seq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_seq <= '0;
      seq_seen <= 1'b0;
      err_seq  <= 1'b0;
    end else begin
      prev_seq <= prev_seq_d;
      seq_seen <= seq_seen_d;
      err_seq  <= err_seq_d;
    end
  end
`else
  assign err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_mcse_gpio_frame_rx.sv
// Directed bench for mcse_gpio_frame_rx: clean frames, backpressure, trailer,
// length, sync and timeout errors, and asynchronous mid-frame reset.
module tb_mcse_gpio_frame_rx;
  import mcse_frame_pkg::*;

`ifdef MCSE_FRAME_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [31:0]  gpio_word;
  logic         gpio_valid;
  logic         gpio_ready;
  logic [255:0] frame_data;
  logic [7:0]   frame_type, frame_len, frame_seq;
  logic         frame_valid, frame_ready;
  logic         err_sync, err_len, err_chk, err_timeout, err_seq;
  logic [7:0]   sync_err_cnt;

  int total = 0;
  int bad   = 0;

  mcse_gpio_frame_rx dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_word    (gpio_word),
    .gpio_valid   (gpio_valid),
    .gpio_ready   (gpio_ready),
    .frame_data   (frame_data),
    .frame_type   (frame_type),
    .frame_len    (frame_len),
    .frame_seq    (frame_seq),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .err_sync     (err_sync),
    .err_len      (err_len),
    .err_chk      (err_chk),
    .err_timeout  (err_timeout),
    .err_seq      (err_seq),
    .sync_err_cnt (sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word and hold it until the handshake edge; bounded wait on gpio_ready
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    gpio_word  = w;
    gpio_valid = 1'b1;
    while (!gpio_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!gpio_ready) check("ready_wait", 256'(gpio_ready), 256'd1);
    @(posedge clk); #1;
    gpio_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; gpio_word = '0; gpio_valid = 1'b0; frame_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   256'(gpio_ready),   256'd1);
    check("rst_valid",   256'(frame_valid),  256'd0);
    check("rst_data",    frame_data,         256'd0);
    check("rst_synccnt", 256'(sync_err_cnt), 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean SHA frame, payload 0..7; trailer = header since 0^1^..^7 = 0
    send_word(32'hA501_0800);
    for (int i = 0; i < 8; i++) send_word(32'(i));
    send_word(32'hA501_0800);
    check("f1_valid", 256'(frame_valid), 256'd1);
    check("f1_data", frame_data,
          256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    check("f1_type", 256'(frame_type), 256'(FRAME_TYPE_SHA));
    check("f1_len",  256'(frame_len),  256'd8);
    check("f1_seq",  256'(frame_seq),  256'd0);
    check("f1_seqerr", 256'(err_seq),  256'd0);
    @(posedge clk); #1;
    check("f1_consumed", 256'(frame_valid), 256'd0);

    // Backpressure: frame 2 held while frame 3 header is offered for 20 cycles
    frame_ready = 1'b0;
    send_word(32'hA503_0205);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    send_word(32'h699A_EA92);
    check("f2_valid",  256'(frame_valid), 256'd1);
    check("f2_seqerr", 256'(err_seq),     SEQ_EN ? 256'd1 : 256'd0);
    gpio_word  = 32'hA502_0106;
    gpio_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_ready", 256'(gpio_ready),  256'd0);
      check("bp_valid", 256'(frame_valid), 256'd1);
      check("bp_data",  frame_data,        256'h12345678_DEADBEEF);
      check("bp_type",  256'(frame_type),  256'(FRAME_TYPE_PUF));
      check("bp_seq",   256'(frame_seq),   256'h05);
    end
    frame_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 256'(frame_valid), 256'd0);
    check("bp_release_ready", 256'(gpio_ready),  256'd1);
    @(posedge clk); #1;
    gpio_valid = 1'b0;
    send_word(32'hCAFE_F00D);
    send_word(32'h6FFC_F10B);
    check("f3_valid",  256'(frame_valid), 256'd1);
    check("f3_data",   frame_data,        256'hCAFEF00D);
    check("f3_type",   256'(frame_type),  256'(FRAME_TYPE_CAM));
    check("f3_len",    256'(frame_len),   256'd1);
    check("f3_seq",    256'(frame_seq),   256'h06);
    check("f3_seqerr", 256'(err_seq),     256'd0);

    // Bad trailer: correct value B4101016 with bit 0 flipped
    send_word(32'hA501_0107);
    send_word(32'h1111_1111);
    send_word(32'hB410_1017);
    check("chk_pulse", 256'(err_chk),     256'd1);
    check("chk_valid", 256'(frame_valid), 256'd0);
    check("chk_data",  frame_data,        256'd0);
    @(posedge clk); #1;
    check("chk_pulse_end", 256'(err_chk), 256'd0);

    // Illegal lengths 9 and 0, then a legal frame
    send_word(32'hA502_0900);
    check("len9",     256'(err_len), 256'd1);
    send_word(32'hA502_0000);
    check("len0",     256'(err_len), 256'd1);
    @(posedge clk); #1;
    check("len_end",  256'(err_len), 256'd0);
    send_word(32'hA501_0108);
    send_word(32'h0000_0001);
    send_word(32'hA501_0109);
    check("f4_valid", 256'(frame_valid), 256'd1);
    check("f4_data",  frame_data,        256'd1);
    check("f4_seq",   256'(frame_seq),   256'h08);
    check("f4_seqerr", 256'(err_seq),    SEQ_EN ? 256'd1 : 256'd0);
    @(posedge clk); #1;

    // 300 garbage words in IDLE: one err_sync each, counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      send_word(32'h1234_5678);
      check("sync_pulse", 256'(err_sync), 256'd1);
      if (i == 100) check("synccnt_100", 256'(sync_err_cnt), 256'd100);
    end
    check("synccnt_sat",   256'(sync_err_cnt), 256'd255);
    check("sync_no_frame", 256'(frame_valid),  256'd0);

    // Header + 3 of 5 payload words, then silence until the timeout fires
    send_word(32'hA503_0509);
    send_word(32'h0000_00AA);
    send_word(32'h0000_00BB);
    send_word(32'h0000_00CC);
    n = 0;
    while (!err_timeout && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    check("tmo_latency", 256'(n), 256'd1024);
    check("tmo_data",    frame_data, 256'd0);
    @(posedge clk); #1;
    check("tmo_pulse_end", 256'(err_timeout), 256'd0);
    send_word(32'hA501_010A);
    send_word(32'h0000_0005);
    send_word(32'hA501_010F);
    check("f5_valid", 256'(frame_valid), 256'd1);
    check("f5_data",  frame_data,        256'd5);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame, asserted between clock edges
    send_word(32'hA501_040B);
    send_word(32'h0000_0077);
    #2 rst = 1'b1;
    #1;
    check("mrst_data",    frame_data,         256'd0);
    check("mrst_type",    256'(frame_type),   256'd0);
    check("mrst_len",     256'(frame_len),    256'd0);
    check("mrst_seq",     256'(frame_seq),    256'd0);
    check("mrst_valid",   256'(frame_valid),  256'd0);
    check("mrst_ready",   256'(gpio_ready),   256'd1);
    check("mrst_synccnt", 256'(sync_err_cnt), 256'd0);
    check("mrst_errs",    256'({err_sync, err_len, err_chk, err_timeout, err_seq}), 256'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    send_word(32'hA502_0100);
    send_word(32'h0000_0007);
    send_word(32'hA502_0107);
    check("f6_valid",  256'(frame_valid), 256'd1);
    check("f6_data",   frame_data,        256'd7);
    check("f6_type",   256'(frame_type),  256'(FRAME_TYPE_CAM));
    check("f6_seqerr", 256'(err_seq),     256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
